interface_output: RTL and testbench
===================================

# interface_output

Downstream output stage of the CORDIC core. Takes the first-quadrant results produced by the `pipeline` stage, applies sector correction to map them back to the full circle, and buffers the corrected samples in a small FIFO. The FIFO drives a valid/ready port to the consumer. The pipeline has no backpressure, so this block detects overflow and drops samples cleanly when the consumer stalls.

## Interface
- `UNSIGNED_OUTPUT_WIDTH`, 16, width of the pipeline x/y/degree results (Q7.8).
- `SECTOR_FLAG_WIDTH`, 2, width of the sector tag.
- `FIFO_DEPTH`, 4, number of FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `valid_in` input 1: pipeline result valid.
- `arctan_en_in` input 1: 1 selects arctan (vectoring) mode, 0 selects rotation mode.
- `sector_in` input `SECTOR_FLAG_WIDTH`: original sector, 0 to 3.
- `x_in`, `y_in` input `UNSIGNED_OUTPUT_WIDTH` each: pipeline magnitudes.
- `degree_in` input `UNSIGNED_OUTPUT_WIDTH`: signed Q7.8 angle or residual.
- `out_ready` input 1: consumer accepts the head entry.
- `clr_ovf` input 1: clears `overflow` (and the drop counter, when compiled in).
- `out_valid` output 1: FIFO is non-empty.
- `out_arctan_en` output 1, `out_sector` output `SECTOR_FLAG_WIDTH`: tags passed through unchanged.
- `out_x`, `out_y` output `UNSIGNED_OUTPUT_WIDTH+1`: signed, corrected coordinates.
- `out_degree` output `UNSIGNED_OUTPUT_WIDTH+2`: signed Q9.8 corrected angle.
- `level` output `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `overflow` output 1: sticky flag, set when a sample is dropped.
- `drop_cnt` output 8: number of dropped samples; present only with the macro defined.

## Operation
- **Stage 1 (correction register).** Registered on every cycle in which `valid_in`=1.
  - `x_in` and `y_in` are zero-extended to 17 bits.
  - `degree_in` is sign-extended to 18 bits.
- **Rotation mode** (`arctan_en_in`=0):
  - Sector 0: (x, y).
  - Sector 1: (−y, x).
  - Sector 2: (−x, −y).
  - Sector 3: (y, −x).
  - Degree passes through unchanged.
- **Arctan mode** (`arctan_en_in`=1):
  - x and y pass through unchanged.
  - Let d be the sign-extended degree and K = 180·256 = 0xB400.
  - Sector 0: d. Sector 1: K − d. Sector 2: d − K. Sector 3: −d.
- **Arithmetic.** Two's complement throughout; the widened outputs never overflow.
- **Stage 2 (FIFO).**
  - The stage-1 entry is written whenever stage-1 valid=1 and (`level` < `FIFO_DEPTH`, or a pop occurs in the same cycle).
  - Otherwise the entry is dropped: `overflow` is set and `drop_cnt` increments.
- **Pop.** A pop occurs on any edge where `out_valid`=1 and `out_ready`=1. Simultaneous push and pop leaves `level` unchanged.
- **Pointers.** Read and write pointers wrap modulo `FIFO_DEPTH`. Output fields are read combinationally from the head entry.
- **Clear vs. set.** `clr_ovf` has priority over a same-cycle set: the flag clears and the drop is not counted.
- **Reset.**
  - Asserting `rst` at any time, including mid-burst, empties the FIFO and clears stage-1 valid.
  - All outputs go to 0 (`out_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, all data fields 0).
  - Entries in flight are discarded.

## Timing
- Latency into an empty FIFO: `valid_in` sampled at edge n → entry in stage 1 after edge n → `out_valid`=1 after edge n+1.
- Sustained throughput is one sample per clock while `out_ready`=1.
- Data holds stable while `out_valid`=1 and `out_ready`=0.
- `level` and `overflow` update on the same edge as the push, pop or drop that changes them.
- `out_ready` does not combinationally affect any output. The only combinational path is head selection from the FIFO memory.

## Configuration
- Macro: `INTERFACE_OUTPUT_DROP_CNT_EN`.
- **Defined:**
  - The `drop_cnt` port and an 8-bit counter are present.
  - The counter increments once per dropped sample and saturates at 255.
  - `clr_ovf` zeroes it.
- **Undefined:** the port and counter do not exist; `overflow` behaves identically.

## Test plan
- **Rotation, sector 1:** x_in=0x00B5, y_in=0x00B5 → out_x=17'h1FF4B, out_y=17'h000B5, `out_valid`=1 two edges after `valid_in`.
- **Arctan, all sectors:** degree_in=0x1E00 (30°).
  - Sector 0 → out_degree=18'h01E00.
  - Sector 1 → 18'h09600.
  - Sector 2 → 18'h36A00.
  - Sector 3 → 18'h3E200.
- **Stall overflow:** FIFO_DEPTH=4, out_ready=0, 6 back-to-back valids → level=4, overflow=1, drop_cnt=2. The first four samples are later popped in order.
- **Full FIFO with simultaneous push/pop:** FIFO full, out_ready=1 while valids continue → no drops, level stays 4, output order preserved.
- **Clear priority:** pulse clr_ovf in the same cycle as a drop → overflow=0, drop_cnt=0 on the next cycle.
- **Reset mid-operation:** assert rst low with level=3 → out_valid=0, level=0 immediately (asynchronous). After release, the first new sample emerges two edges after its `valid_in`.

Source files
------------

// File: rtl/interface_output.sv
// interface_output: CORDIC sector correction followed by a small valid/ready FIFO with overflow detection.
// Optional 8-bit saturating drop counter is compiled in with INTERFACE_OUTPUT_DROP_CNT_EN.
module interface_output #(
    parameter int UNSIGNED_OUTPUT_WIDTH = 16,
    parameter int SECTOR_FLAG_WIDTH     = 2,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic                               arctan_en_in,
    input  logic [SECTOR_FLAG_WIDTH-1:0]       sector_in,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0]   x_in,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0]   y_in,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0]   degree_in,
    input  logic                               out_ready,
    input  logic                               clr_ovf,
    output logic                               out_valid,
    output logic                               out_arctan_en,
    output logic [SECTOR_FLAG_WIDTH-1:0]       out_sector,
    output logic [UNSIGNED_OUTPUT_WIDTH:0]     out_x,
    output logic [UNSIGNED_OUTPUT_WIDTH:0]     out_y,
    output logic [UNSIGNED_OUTPUT_WIDTH+1:0]   out_degree,
    output logic [$clog2(FIFO_DEPTH):0]        level,
    output logic                               overflow
`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
    ,
    output logic [7:0]                         drop_cnt
`endif
);

    localparam int W     = UNSIGNED_OUTPUT_WIDTH;
    localparam int SW    = SECTOR_FLAG_WIDTH;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam int ENT_W = 1 + SW + 2 * (W + 1) + (W + 2);

    localparam logic [W+1:0] HALF_TURN = (W+2)'(180 * 256);

    logic [W:0]   x_ext, y_ext, cx, cy;
    logic [W+1:0] d_ext, cd;

    always_comb begin
        x_ext = {1'b0, x_in};
        y_ext = {1'b0, y_in};
        d_ext = {{2{degree_in[W-1]}}, degree_in};
        cx    = x_ext;
        cy    = y_ext;
        cd    = d_ext;
        if (!arctan_en_in) begin
            case (sector_in)
                SW'(1): begin cx = -y_ext; cy = x_ext;  end
                SW'(2): begin cx = -x_ext; cy = -y_ext; end
                SW'(3): begin cx = y_ext;  cy = -x_ext; end
                default: ;
            endcase
        end else begin
            case (sector_in)
                SW'(1):  cd = HALF_TURN - d_ext;
                SW'(2):  cd = d_ext - HALF_TURN;
                SW'(3):  cd = -d_ext;
                default: cd = d_ext;
            endcase
        end
    end

    logic             s1_valid;
    logic [ENT_W-1:0] s1_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in)
                s1_entry <= {arctan_en_in, sector_in, cx, cy, cd};
        end
    end

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop, drop;
    logic [ENT_W-1:0] head;

    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts the new entry when the head leaves on the same edge.
    assign push      = s1_valid & ((level < LW'(FIFO_DEPTH)) | pop);
    assign drop      = s1_valid & ~push;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overflow <= 1'b0;
        else if (clr_ovf)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt <= '0;
        else if (clr_ovf)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end
`endif

    // Memory is not reset, so the head is masked to zero while the FIFO is empty.
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_arctan_en, out_sector, out_x, out_y, out_degree} = head;

endmodule

// File: tb/tb_interface_output.sv
// Self-checking bench for interface_output: directed scenarios plus random traffic against a queue model.
module tb_interface_output;

    localparam int W  = 16;
    localparam int SW = 2;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic          arctan_en_in = 1'b0;
    logic [SW-1:0] sector_in = '0;
    logic [W-1:0]  x_in = '0;
    logic [W-1:0]  y_in = '0;
    logic [W-1:0]  degree_in = '0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_valid;
    logic          out_arctan_en;
    logic [SW-1:0] out_sector;
    logic [W:0]    out_x;
    logic [W:0]    out_y;
    logic [W+1:0]  out_degree;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    interface_output #(
        .UNSIGNED_OUTPUT_WIDTH(W),
        .SECTOR_FLAG_WIDTH(SW),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .arctan_en_in(arctan_en_in),
        .sector_in(sector_in),
        .x_in(x_in),
        .y_in(y_in),
        .degree_in(degree_in),
        .out_ready(out_ready),
        .clr_ovf(clr_ovf),
        .out_valid(out_valid),
        .out_arctan_en(out_arctan_en),
        .out_sector(out_sector),
        .out_x(out_x),
        .out_y(out_y),
        .out_degree(out_degree),
        .level(level),
        .overflow(overflow)
`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          a;
        logic [SW-1:0] s;
        logic [W:0]    x;
        logic [W:0]    y;
        logic [W+1:0]  d;
    } ent_t;

    ent_t q[$];
    ent_t pend;
    bit   pend_v = 1'b0;
    bit   m_ovf  = 1'b0;
    int   m_cnt  = 0;
    int   total  = 0;
    int   bad    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Expected full-circle result computed from signed integer arithmetic.
    function automatic ent_t mk(input logic a, input logic [SW-1:0] s,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] d);
        ent_t e;
        int xi, yi, di, xr, yr, dr;
        xi = int'(x);
        yi = int'(y);
        di = int'($signed(d));
        xr = xi; yr = yi; dr = di;
        if (!a) begin
            if (s == 1)      begin xr = -yi; yr = xi;  end
            else if (s == 2) begin xr = -xi; yr = -yi; end
            else if (s == 3) begin xr = yi;  yr = -xi; end
        end else begin
            if (s == 1)      dr = 46080 - di;
            else if (s == 2) dr = di - 46080;
            else if (s == 3) dr = -di;
        end
        e.a = a;
        e.s = s;
        e.x = (W+1)'(xr);
        e.y = (W+1)'(yr);
        e.d = (W+2)'(dr);
        return e;
    endfunction

    task automatic model_edge();
        bit pop, drop;
        pop  = (q.size() > 0) && out_ready;
        drop = 1'b0;
        if (pop)
            void'(q.pop_front());
        if (pend_v) begin
            if (q.size() < D) q.push_back(pend);
            else              drop = 1'b1;
        end
        if (clr_ovf) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        pend_v = valid_in;
        pend   = mk(arctan_en_in, sector_in, x_in, y_in, degree_in);
    endtask

    task automatic check_all();
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
        if (q.size() != 0) begin
            chk("out_x", 32'(out_x), 32'(q[0].x));
            chk("out_y", 32'(out_y), 32'(q[0].y));
            chk("out_degree", 32'(out_degree), 32'(q[0].d));
            chk("out_sector", 32'(out_sector), 32'(q[0].s));
            chk("out_arctan_en", 32'(out_arctan_en), 32'(q[0].a));
        end else begin
            chk("empty_data", 32'({out_arctan_en, out_sector, out_x[0], out_y[0], out_degree}), 32'(0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic a, input logic [SW-1:0] s,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] d);
        valid_in     = v;
        arctan_en_in = a;
        sector_in    = s;
        x_in         = x;
        y_in         = y;
        degree_in    = d;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, 1'($urandom), SW'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    logic [W+1:0] kdeg [4];

    initial begin
        kdeg[0] = 18'h01E00;
        kdeg[1] = 18'h09600;
        kdeg[2] = 18'h36A00;
        kdeg[3] = 18'h3E200;

        // Reset state
        #12;
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;

        // Rotation sector 1 with two-edge latency
        drive(1'b1, 1'b0, 2'd1, 16'h00B5, 16'h00B5, 16'h0000);
        step();
        chk("lat_edge1_valid", 32'(out_valid), 32'(0));
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        step();
        chk("lat_edge2_valid", 32'(out_valid), 32'(1));
        chk("rot_s1_x", 32'(out_x), 32'(17'h1FF4B));
        chk("rot_s1_y", 32'(out_y), 32'(17'h000B5));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Arctan correction in every sector
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b1, SW'(s), 16'h1234, 16'h0042, 16'h1E00);
            step();
            drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
            step();
            chk("atan_deg", 32'(out_degree), 32'(kdeg[s]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Stall: six back-to-back samples into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            drive_rand(1'b1);
            step();
        end
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        step();
        step();
        chk("stall_level", 32'(level), 32'(4));
        chk("stall_ovf", 32'(overflow), 32'(1));
`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
        chk("stall_drops", 32'(drop_cnt), 32'(2));
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            step();
        end
        chk("full_level", 32'(level), 32'(4));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            step();
            chk("pp_level", 32'(level), 32'(4));
            chk("pp_noovf", 32'(overflow), 32'(0));
        end
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        for (int i = 0; i < 6; i++) step();

        // Clear takes priority over a same-edge drop
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            step();
        end
        clr_ovf = 1'b1;
        step();
        chk("clr_prio_ovf", 32'(overflow), 32'(0));
`ifdef INTERFACE_OUTPUT_DROP_CNT_EN
        chk("clr_prio_cnt", 32'(drop_cnt), 32'(0));
`endif
        clr_ovf = 1'b0;
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        step();
        out_ready = 1'b1;
        clr_ovf   = 1'b1;
        for (int i = 0; i < 6; i++) step();
        clr_ovf = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr_ovf   = 1'($urandom_range(0, 19) == 0);
            step();
        end
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        for (int i = 0; i < 6; i++) step();

        // Asynchronous reset with three entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            step();
        end
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        step();
        chk("pre_rst_level", 32'(level), 32'(3));
        #3 rst = 1'b0;
        #1;
        q.delete();
        pend_v = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        chk("arst_valid", 32'(out_valid), 32'(0));
        chk("arst_level", 32'(level), 32'(0));
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 1'b0, 2'd2, 16'h0101, 16'h0202, 16'h0303);
        step();
        chk("post_rst_edge1", 32'(out_valid), 32'(0));
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        step();
        chk("post_rst_edge2", 32'(out_valid), 32'(1));
        chk("post_rst_x", 32'(out_x), 32'(17'h1FEFF));
        out_ready = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
